rtc_bus_ctrl: RTL

Bus initiator for the external RTC's multiplexed address/data port: the data producer that feeds the VGA `Interfaz` block. On each frame-end tick it reads the clock registers, plus the timer registers when `temporizador` is high, and streams each byte with its index to the display side. Between scans it executes single-register write requests coming from the time-setting logic.

---
 rtl/rtc_pkg.sv | 39 +++
 rtl/rtc_phase_timer.sv | 23 ++
 rtl/rtc_bus_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus initiator: register address map,
// register index constants and the bus FSM state type.
package rtc_pkg;

  localparam int N_RTC_REGS = 13;

  localparam logic [3:0] IDX_HUND      = 4'd0;
  localparam logic [3:0] IDX_SEC       = 4'd1;
  localparam logic [3:0] IDX_MIN       = 4'd2;
  localparam logic [3:0] IDX_HOUR      = 4'd3;
  localparam logic [3:0] IDX_DATE      = 4'd4;
  localparam logic [3:0] IDX_MONTH     = 4'd5;
  localparam logic [3:0] IDX_YEAR      = 4'd6;
  localparam logic [3:0] IDX_WEEKDAY   = 4'd7;
  localparam logic [3:0] IDX_WEEKNUM   = 4'd8;
  localparam logic [3:0] IDX_TMR_HUND  = 4'd9;
  localparam logic [3:0] IDX_TMR_SEC   = 4'd10;
  localparam logic [3:0] IDX_TMR_MIN   = 4'd11;
  localparam logic [3:0] IDX_TMR_HOUR  = 4'd12;

  // Clock registers first, timer registers appended so a scan is a prefix read.
  localparam logic [7:0] RTC_ADDR [0:N_RTC_REGS-1] = '{
    8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
    8'h40, 8'h41, 8'h42, 8'h43
  };

  typedef enum logic [2:0] {
    IDLE,
    A_ASSERT,
    A_RELEASE,
    D_ASSERT,
    D_RELEASE
  } busState_t;

  function automatic logic [7:0] rtcAddr(input logic [3:0] idx);
    return (idx <= IDX_TMR_HOUR) ? RTC_ADDR[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter; tc marks the last cycle of the current bus phase.
module rtc_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] loadVal,
  output logic       tc
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= 8'd0;
    else if (load)
      cnt <= loadVal;
    else if (cnt != 8'd0)
      cnt <= cnt - 8'd1;
  end

  assign tc = (cnt == 8'd0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Multiplexed-AD bus initiator for the external RTC: scans clock/timer
// registers on each frame tick and executes single-register writes between scans.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int T_PHASE    = 10,
  parameter int N_CLK_REGS = 9,
  parameter int N_TMR_REGS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       temporizador,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       busy,
  output logic [7:0] dato_out,
  output logic [3:0] dato_idx,
  output logic       dato_valid,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d
);

  localparam logic [7:0] PHASE_LOAD = 8'(T_PHASE - 1);
  localparam logic [3:0] LAST_CLK   = 4'(N_CLK_REGS - 1);
  localparam logic [3:0] LAST_TMR   = 4'(N_CLK_REGS + N_TMR_REGS - 1);

  busState_t  state, nextState;
  logic       phaseEnd;
  logic       pending;
  logic       isWrite;
  logic       startWrite, startScan;
  logic [3:0] idx, lastIdx;
  logic [7:0] wrAddrQ, wrDataQ, curAddr;

  // Every state change restarts the phase count, so each state lasts T_PHASE cycles.
  rtc_phase_timer uPhaseTimer (
    .clk     (clk),
    .reset   (reset),
    .load    (nextState != state),
    .loadVal (PHASE_LOAD),
    .tc      (phaseEnd)
  );

  always_comb begin
    nextState  = state;
    startWrite = 1'b0;
    startScan  = 1'b0;
    cs_n       = 1'b1;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    a_d        = 1'b1;
    ad_oe      = 1'b0;
    ad_out     = 8'h00;
    wr_ack     = 1'b0;
    curAddr    = isWrite ? wrAddrQ : rtcAddr(idx);
    unique case (state)
      IDLE: begin
        if (wr_req) begin
          startWrite = 1'b1;
          nextState  = A_ASSERT;
        end else if (tick || pending) begin
          startScan = 1'b1;
          nextState = A_ASSERT;
        end
      end
      A_ASSERT: begin
        cs_n   = 1'b0;
        wr_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = curAddr;
        if (phaseEnd) nextState = A_RELEASE;
      end
      A_RELEASE: begin
        cs_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = curAddr;
        if (phaseEnd) nextState = D_ASSERT;
      end
      D_ASSERT: begin
        cs_n = 1'b0;
        a_d  = 1'b0;
        if (isWrite) begin
          wr_n   = 1'b0;
          ad_oe  = 1'b1;
          ad_out = wrDataQ;
        end else begin
          rd_n = 1'b0;
        end
        if (phaseEnd) nextState = D_RELEASE;
      end
      D_RELEASE: begin
        a_d = 1'b0;
        if (phaseEnd) begin
          if (isWrite) begin
            wr_ack    = 1'b1;
            nextState = IDLE;
          end else if (idx == lastIdx) begin
            nextState = IDLE;
          end else begin
            nextState = A_ASSERT;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      isWrite    <= 1'b0;
      idx        <= 4'd0;
      lastIdx    <= 4'd0;
      dato_out   <= 8'h00;
      dato_idx   <= 4'd0;
      dato_valid <= 1'b0;
    end else begin
      state      <= nextState;
      dato_valid <= 1'b0;
      // Ticks are remembered only while a write owns the bus; during a scan they are dropped.
      if (startWrite) begin
        isWrite <= 1'b1;
        pending <= pending | tick;
      end else if (startScan) begin
        isWrite <= 1'b0;
        pending <= 1'b0;
        idx     <= 4'd0;
        lastIdx <= temporizador ? LAST_TMR : LAST_CLK;
      end else if (tick && isWrite && state != IDLE) begin
        pending <= 1'b1;
      end
      if (state == D_RELEASE && phaseEnd && !isWrite && idx != lastIdx)
        idx <= idx + 4'd1;
      if (state == D_ASSERT && phaseEnd && !isWrite) begin
        dato_out   <= ad_in;
        dato_idx   <= idx;
        dato_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (startWrite) begin
      wrAddrQ <= wr_addr;
      wrDataQ <= wr_data;
    end
  end

endmodule
